// File: rtl/mem_if.sv
// CPU-side request/completion bus for the banked memory controller.
// Master drives requests; slave answers with ready and completion pulses.
interface mem_if #(
  parameter int DWIDTH    = 32,
  parameter int CPUAWIDTH = 32
);
  logic                  valid;
  logic                  rw;
  logic [CPUAWIDTH-1:0]  addr;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   be;
  logic                  ready;
  logic [DWIDTH-1:0]     rdata;
  logic                  rvalid;
  logic                  wack;
  logic                  err;

  modport master (
    output valid, rw, addr, wdata, be,
    input  ready, rdata, rvalid, wack, err
  );

  modport slave (
    input  valid, rw, addr, wdata, be,
    output ready, rdata, rvalid, wack, err
  );
endinterface

// File: rtl/banked_mem_ctrl.sv
// Single-outstanding load/store controller over NBANKS word-interleaved
// RAM banks with byte-enable writes and misaligned/out-of-range rejection.
module banked_mem_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int CPUAWIDTH = 32,
  parameter int AWIDTH    = 8,
  parameter int NBANKS    = 4
) (
  input logic clk,
  input logic reset,
  mem_if.slave bus
);
  localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int BWI   = (BW > 0) ? BW : 1;
  localparam int NBE   = DWIDTH / 8;
  localparam int UPLSB = 2 + BW + AWIDTH;
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 rw_q;
  logic [CPUAWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0]    wdata_q;
  logic [NBE-1:0]       be_q;
  logic [DWIDTH-1:0]    rdata_q, rdata_d;

  logic [DWIDTH-1:0]    mem_q [NBANKS][DEPTH];

  logic [BWI-1:0]       bank;
  logic [AWIDTH-1:0]    row;
  logic                 misal;
  logic                 oor;
  logic                 rej;
  logic                 accept;

  generate
    if (BW == 0) begin : g_onebank
      assign bank = '0;
    end else begin : g_banks
      assign bank = addr_q[2 +: BWI];
    end
  endgenerate

  assign row    = addr_q[2+BW +: AWIDTH];
  assign misal  = |addr_q[1:0];
  assign oor    = |(addr_q >> UPLSB);
  assign rej    = misal | oor;
  assign accept = bus.valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = DONE;
        if (rw_q) rdata_d = rej ? '0 : mem_q[bank][row];
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        rw_q    <= bus.rw;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.be;
      end
    end
  end

  // Bank contents survive reset; reset only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (reset && state_q == ACCESS && !rw_q && !rej) begin
      for (int i = 0; i < NBE; i++) begin
        if (be_q[i]) mem_q[bank][row][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.rvalid = (state_q == DONE) && rw_q;
  assign bus.wack   = (state_q == DONE) && !rw_q;
  assign bus.err    = (state_q == DONE) && rej;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Table-driven bench with a completion scoreboard for banked_mem_ctrl.
// Hand sequences cover mid-op reset and back-to-back accept spacing.
module tb_banked_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_if bus ();

  banked_mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (bus.rvalid || bus.wack)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_pulse: rvalid=%b wack=%b with nothing pending",
                 bus.rvalid, bus.wack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind_rvalid", 32'(bus.rvalid), 32'(e.rw));
        chk("kind_wack", 32'(bus.wack), 32'(!e.rw));
        chk("err", 32'(bus.err), 32'(e.err));
        if (e.rw) chk("rdata", bus.rdata, e.rdata);
        chk("latency", 32'(cyc - e.acc), 32'd1);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d completions outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_req(vec_t v);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.valid = 1'b1;
    bus.rw    = v.rw;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    bus.be    = v.be;
    e.rw    = v.rw;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.acc   = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.valid = 1'b0;
    bus.wdata = 32'h0BAD_F00D;
    bus.addr  = 32'h0000_0040;
    bus.be    = 4'hF;
    wait_done();
  endtask

  function automatic vec_t mk(logic rw, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] be, logic [31:0] rd, logic er);
    vec_t v;
    v.rw = rw; v.addr = a; v.wdata = wd;
    v.be = be; v.rdata = rd; v.err = er;
    return v;
  endfunction

  initial begin
    int acc_cyc[$];
    bus.valid = 1'b0;
    bus.rw    = 1'b1;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_wack", 32'(bus.wack), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b1;

    vecs.push_back(mk(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 32'h10, 32'h11223344, 4'b0101, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 32'hDE22BE44, 0));
    vecs.push_back(mk(0, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 32'hDE22BE44, 0));
    vecs.push_back(mk(0, 32'h0, 32'd1, 4'hF, 0, 0));
    vecs.push_back(mk(0, 32'h4, 32'd2, 4'hF, 0, 0));
    vecs.push_back(mk(0, 32'h8, 32'd3, 4'hF, 0, 0));
    vecs.push_back(mk(0, 32'hC, 32'd4, 4'hF, 0, 0));
    vecs.push_back(mk(0, 32'hFFC, 32'hA5A5A5A5, 4'hF, 0, 0));
    vecs.push_back(mk(1, 32'h0, 0, 0, 32'd1, 0));
    vecs.push_back(mk(1, 32'h4, 0, 0, 32'd2, 0));
    vecs.push_back(mk(1, 32'h8, 0, 0, 32'd3, 0));
    vecs.push_back(mk(1, 32'hC, 0, 0, 32'd4, 0));
    vecs.push_back(mk(1, 32'hFFC, 0, 0, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 32'hDE22BE44, 0));
    vecs.push_back(mk(1, 32'h12, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h1000, 32'hBAD0BAD0, 4'hF, 0, 1));
    vecs.push_back(mk(0, 32'h13, 32'h0, 4'hF, 0, 1));
    vecs.push_back(mk(1, 32'h0, 0, 0, 32'd1, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 32'hDE22BE44, 0));
    vecs.push_back(mk(1, 32'hFFC, 0, 0, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(1, 32'h8000_0000, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h20, 32'h5555AAAA, 4'hF, 0, 0));

    foreach (vecs[i]) do_req(vecs[i]);

    // reset while a write to 0x20 sits in ACCESS
    @(negedge clk);
    bus.valid = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 32'h20;
    bus.wdata = 32'h99999999;
    bus.be    = 4'hF;
    @(negedge clk);
    bus.valid = 1'b0;
    chk("midop_in_access", 32'(bus.ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midop_ready", 32'(bus.ready), 32'd1);
    chk("midop_wack", 32'(bus.wack), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    do_req(mk(1, 32'h20, 0, 0, 32'h5555AAAA, 0));

    // valid held high: accepts must be 3 cycles apart
    @(negedge clk);
    bus.valid = 1'b1;
    bus.rw    = 1'b1;
    bus.addr  = 32'h8;
    for (int k = 0; k < 12; k++) begin
      if (bus.ready) begin
        exp_t e;
        e.rw = 1'b1; e.rdata = 32'd3; e.err = 1'b0; e.acc = cyc + 1;
        sb.push_back(e);
        acc_cyc.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    bus.valid = 1'b0;
    wait_done();
    chk("held_accepts", 32'(acc_cyc.size()), 32'd4);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("accept_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
